// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit 7-segment scan driver: scan state
// encoding and active-high segment patterns on gfedcba.
package seg7_pkg;

   localparam logic [1:0] ST_SHOW_U = 2'd0;
   localparam logic [1:0] ST_GAP_U  = 2'd1;
   localparam logic [1:0] ST_SHOW_T = 2'd2;
   localparam logic [1:0] ST_GAP_T  = 2'd3;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/module_seg7_decoder.sv
// Combinational BCD nibble to active-high segment pattern; codes above 9
// render as a dash, and blank overrides everything.
module module_seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/module_seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver: scans units then tens with an
// all-anodes-off guard gap after each digit, latching bcd_i once per frame.
module module_seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 27000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter logic        SEG_ACTIVE_LOW = 1'b1,
   parameter logic        AN_ACTIVE_LOW  = 1'b1,
   parameter logic        LZ_BLANK       = 1'b1
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] bcd_i,
   output logic [6:0] seg_o,
   output logic [1:0] an_o,
   output logic       frame_o
);

   localparam int unsigned MAX_DWELL = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       frame_q, frame_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             framePulse_q;

   logic             isShow;
   logic             dwellDone;
   logic             latchNow;
   logic [3:0]       digitNibble;
   logic             digitBlank;
   logic [6:0]       digitSeg;

   assign isShow    = (state_q == ST_SHOW_U) || (state_q == ST_SHOW_T);
   assign dwellDone = isShow ? (cnt_q == SHOW_LAST) : (cnt_q == GAP_LAST);
   assign latchNow  = (state_q == ST_GAP_T) && dwellDone;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      frame_d = latchNow ? bcd_i : frame_q;
      if (dwellDone) begin
         cnt_d = '0;
         case (state_q)
            ST_SHOW_U: state_d = ST_GAP_U;
            ST_GAP_U:  state_d = ST_SHOW_T;
            ST_SHOW_T: state_d = ST_GAP_T;
            default:   state_d = ST_SHOW_U;
         endcase
      end
   end

   // An invalid tens nibble is nonzero, so it can never hit the leading-zero blank.
   assign digitNibble = (state_q == ST_SHOW_T) ? frame_q[7:4] : frame_q[3:0];
   assign digitBlank  = !isShow ||
                        ((state_q == ST_SHOW_T) && LZ_BLANK && (frame_q[7:4] == 4'd0));

   module_seg7_decoder uDecoder (
      .nibble_i (digitNibble),
      .blank_i  (digitBlank),
      .seg_o    (digitSeg)
   );

   always_comb begin
      seg_d = digitSeg;
      case (state_q)
         ST_SHOW_U: an_d = 2'b01;
         ST_SHOW_T: an_d = 2'b10;
         default:   an_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_GAP_T;
         cnt_q        <= GAP_LAST;
         frame_q      <= 8'h00;
         seg_q        <= SEG_BLANK;
         an_q         <= 2'b00;
         framePulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_q      <= frame_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         framePulse_q <= latchNow;
      end
   end

   assign seg_o   = seg_q ^ {7{SEG_ACTIVE_LOW}};
   assign an_o    = an_q ^ {2{AN_ACTIVE_LOW}};
   assign frame_o = framePulse_q;

endmodule

// File: tb/tb_module_seg7_mux_driver.sv
// Randomised bench for the 7-segment scan driver, checked against a frame-
// position model with two instances covering both blanking/polarity setups.
module tb_module_seg7_mux_driver;

   localparam int R     = 4;
   localparam int B     = 2;
   localparam int FRAME = 2 * (R + B);

   localparam logic [6:0] DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] bcd = 8'h00;

   logic [6:0] segA, segB;
   logic [1:0] anA, anB;
   logic       frmA, frmB;

   int         testsRun    = 0;
   int         testsFailed = 0;

   int         edgesSinceRelease = 0;
   bit         modelInReset = 1'b1;
   logic [7:0] modelFrame = 8'h00;

   always #5 clk = ~clk;

   module_seg7_mux_driver #(
      .REFRESH_CYCLES (R),
      .BLANK_CYCLES   (B),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1),
      .LZ_BLANK       (1'b1)
   ) dutA (
      .clk_i   (clk),
      .rst_i   (rst),
      .bcd_i   (bcd),
      .seg_o   (segA),
      .an_o    (anA),
      .frame_o (frmA)
   );

   module_seg7_mux_driver #(
      .REFRESH_CYCLES (R),
      .BLANK_CYCLES   (B),
      .SEG_ACTIVE_LOW (1'b0),
      .AN_ACTIVE_LOW  (1'b0),
      .LZ_BLANK       (1'b0)
   ) dutB (
      .clk_i   (clk),
      .rst_i   (rst),
      .bcd_i   (bcd),
      .seg_o   (segB),
      .an_o    (anB),
      .frame_o (frmB)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %02h, expected %02h", tag, $time, observed, expected);
      end
   endtask

   function automatic logic [6:0] digitPattern(input logic [3:0] n);
      if (n > 4'd9) return 7'h40;
      return DIGITS[n];
   endfunction

   // Output k cycles after reset release sits at frame position (k-1) mod FRAME.
   function automatic void expectedOutputs(input bit lzBlank, input bit segLow, input bit anLow,
                                           output logic [6:0] seg, output logic [1:0] an,
                                           output logic frm);
      int p;
      seg = 7'h00;
      an  = 2'b00;
      frm = 1'b0;
      if (!modelInReset) begin
         p   = (edgesSinceRelease - 1) % FRAME;
         frm = (p == 0);
         if (p >= 1 && p <= R) begin
            an  = 2'b01;
            seg = digitPattern(modelFrame[3:0]);
         end else if (p >= R + B + 1 && p <= 2 * R + B) begin
            an  = 2'b10;
            seg = (lzBlank && modelFrame[7:4] == 4'd0) ? 7'h00 : digitPattern(modelFrame[7:4]);
         end
      end
      seg = seg ^ {7{segLow}};
      an  = an ^ {2{anLow}};
   endfunction

   task automatic checkAll();
      logic [6:0] expSeg;
      logic [1:0] expAn;
      logic       expFrm;
      expectedOutputs(1'b1, 1'b1, 1'b1, expSeg, expAn, expFrm);
      checkOutput("segA", {1'b0, segA}, {1'b0, expSeg});
      checkOutput("anA", {6'd0, anA}, {6'd0, expAn});
      checkOutput("frameA", {7'd0, frmA}, {7'd0, expFrm});
      expectedOutputs(1'b0, 1'b0, 1'b0, expSeg, expAn, expFrm);
      checkOutput("segB", {1'b0, segB}, {1'b0, expSeg});
      checkOutput("anB", {6'd0, anB}, {6'd0, expAn});
      checkOutput("frameB", {7'd0, frmB}, {7'd0, expFrm});
   endtask

   task automatic applyStimulus(input logic rstVal, input logic [7:0] bcdVal, input int cycles);
      repeat (cycles) begin
         rst = rstVal;
         bcd = bcdVal;
         @(posedge clk);
         #1;
         if (rstVal) begin
            modelInReset      = 1'b1;
            edgesSinceRelease = 0;
            modelFrame        = 8'h00;
         end else begin
            modelInReset = 1'b0;
            edgesSinceRelease++;
            if ((edgesSinceRelease - 1) % FRAME == 0) modelFrame = bcdVal;
         end
         checkAll();
      end
   endtask

   function automatic logic [7:0] randomBcd();
      logic [7:0] v;
      case ($urandom_range(0, 9))
         0:       v = 8'($urandom_range(0, 255));
         1, 2:    v = {4'd0, 4'($urandom_range(0, 9))};
         default: v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      return v;
   endfunction

   initial begin
      logic [7:0] curBcd;
      logic       curRst;

      applyStimulus(1'b1, 8'h00, 3);

      applyStimulus(1'b0, 8'h42, 2 * FRAME);
      applyStimulus(1'b0, 8'h42, R + B + 2);
      applyStimulus(1'b0, 8'h97, 2 * FRAME);
      applyStimulus(1'b0, 8'h07, 2 * FRAME);
      applyStimulus(1'b0, 8'hA3, 2 * FRAME);

      // Step into the middle of SHOW_U before pulsing reset.
      for (int i = 0; i < FRAME && ((edgesSinceRelease - 1) % FRAME) != 2; i++)
         applyStimulus(1'b0, 8'hA3, 1);
      applyStimulus(1'b1, 8'h58, 1);
      applyStimulus(1'b0, 8'h58, 2 * FRAME);

      curBcd = 8'h31;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) curBcd = randomBcd();
         curRst = ($urandom_range(0, 299) == 0);
         applyStimulus(curRst, curBcd, 1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
